// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit with forwarding, load-use stall, branch flush and memory-wait FSM.
// Keeps shadow E/M/W destination/control registers advanced with the same stall/flush it emits.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  RA1D,
    input  logic [3:0]  RA2D,
    input  logic [3:0]  RSD,
    input  logic [3:0]  WA3D,
    input  logic        RegWriteD,
    input  logic        MemtoRegD,
    input  logic        BranchTakenE,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic [1:0]  ForwardSE,
    output logic [15:0] StallCount,
    output logic [1:0]  HazState
);
    localparam logic [1:0] RUN = 2'b00, MEMWAIT = 2'b01, BRFLUSH = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  ra1_e_q, ra1_e_d, ra2_e_q, ra2_e_d, rs_e_q, rs_e_d;
    logic [3:0]  wa3_e_q, wa3_e_d, wa3_m_q, wa3_m_d, wa3_w_q, wa3_w_d;
    logic        rw_e_q, rw_e_d, mtr_e_q, mtr_e_d;
    logic        rw_m_q, rw_m_d, mtr_m_q, mtr_m_d;
    logic        rw_w_q, rw_w_d;
    logic        ld_stall;

    // R15 is the PC and is never forwarded; M result beats W result
    function automatic logic [1:0] fwd_sel(input logic [3:0] src);
        return (src == 4'hF) ? 2'b00 :
               (rw_m_q && wa3_m_q == src) ? 2'b10 :
               (rw_w_q && wa3_w_q == src) ? 2'b01 : 2'b00;
    endfunction

    always_comb begin
        ld_stall = mtr_e_q & rw_e_q & (wa3_e_q != 4'hF) &
                   (RA1D == wa3_e_q | RA2D == wa3_e_q | RSD == wa3_e_q);
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        StallM  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        state_d = RUN;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (!MemReadyM) begin
            {StallF, StallD, StallE, StallM} = 4'b1111;
            state_d = MEMWAIT;
        end else if (state_q == BRFLUSH) begin
            FlushD = 1'b1;
        end else if (BranchTakenE) begin
            FlushD  = 1'b1;
            FlushE  = 1'b1;
            state_d = BRFLUSH;
        end else if (ld_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
        ra1_e_d = StallE ? ra1_e_q : RA1D;
        ra2_e_d = StallE ? ra2_e_q : RA2D;
        rs_e_d  = StallE ? rs_e_q  : RSD;
        wa3_e_d = StallE ? wa3_e_q : WA3D;
        rw_e_d  = StallE ? rw_e_q  : RegWriteD & ~FlushE;
        mtr_e_d = StallE ? mtr_e_q : MemtoRegD & ~FlushE;
        wa3_m_d = StallM ? wa3_m_q : wa3_e_q;
        rw_m_d  = StallM ? rw_m_q  : rw_e_q;
        mtr_m_d = StallM ? mtr_m_q : mtr_e_q;
        wa3_w_d = wa3_m_q;
        rw_w_d  = StallM ? 1'b0 : rw_m_q;
        cnt_d   = (StallF && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        ForwardAE  = reset ? 2'b00 : fwd_sel(ra1_e_q);
        ForwardBE  = reset ? 2'b00 : fwd_sel(ra2_e_q);
        ForwardSE  = reset ? 2'b00 : fwd_sel(rs_e_q);
        HazState   = reset ? RUN : state_q;
        StallCount = reset ? 16'd0 : cnt_q;
    end

    always_ff @(posedge clk) begin
        ra1_e_q <= ra1_e_d;
        ra2_e_q <= ra2_e_d;
        rs_e_q  <= rs_e_d;
        wa3_e_q <= wa3_e_d;
        wa3_m_q <= wa3_m_d;
        wa3_w_q <= wa3_w_d;
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 16'd0;
            rw_e_q  <= 1'b0;
            mtr_e_q <= 1'b0;
            rw_m_q  <= 1'b0;
            mtr_m_q <= 1'b0;
            rw_w_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_e_q  <= rw_e_d;
            mtr_e_q <= mtr_e_d;
            rw_m_q  <= rw_m_d;
            mtr_m_q <= mtr_m_d;
            rw_w_q  <= rw_w_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed cycle vectors; driver queues expected outputs, negedge monitor compares.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  RA1D = '0, RA2D = '0, RSD = '0, WA3D = '0;
    logic        RegWriteD = 1'b0, MemtoRegD = 1'b0, BranchTakenE = 1'b0, MemReadyM = 1'b1;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE, ForwardSE, HazState;
    logic [15:0] StallCount;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RSD(RSD), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchTakenE(BranchTakenE),
        .MemReadyM(MemReadyM), .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .ForwardSE(ForwardSE), .StallCount(StallCount),
        .HazState(HazState)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [7:0]  ctl;
        logic [15:0] cnt;
        logic        fchk;
        logic [5:0]  fw;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          id_n = 0;
    logic [15:0] exp_cnt = 16'd0;

    // stl = {F,D,E,M}, fl = {D,E}, fw = {AE,BE,SE}
    task automatic step(input logic [3:0] ra1, ra2, rs, wa3, input logic rw, mtr, br, rdy, rst, chk,
                        input logic [3:0] stl, input logic [1:0] fl, input logic [1:0] st,
                        input logic fchk, input logic [5:0] fw);
        exp_t e;
        @(posedge clk);
        #1;
        RA1D = ra1; RA2D = ra2; RSD = rs; WA3D = wa3;
        RegWriteD = rw; MemtoRegD = mtr; BranchTakenE = br; MemReadyM = rdy; reset = rst;
        if (chk) begin
            e.id = id_n; e.ctl = {stl, fl, st}; e.cnt = rst ? 16'd0 : exp_cnt;
            e.fchk = fchk; e.fw = fw;
            sb.push_back(e);
        end
        id_n++;
        exp_cnt = rst ? 16'd0 : (stl[3] && exp_cnt != 16'hFFFF) ? exp_cnt + 16'd1 : exp_cnt;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({StallF, StallD, StallE, StallM, FlushD, FlushE, HazState} !== e.ctl) begin
                errors++;
                $display("FAIL ctl cycle %0d: got %b want %b", e.id,
                         {StallF, StallD, StallE, StallM, FlushD, FlushE, HazState}, e.ctl);
            end
            checks++;
            if (StallCount !== e.cnt) begin
                errors++;
                $display("FAIL count cycle %0d: got %h want %h", e.id, StallCount, e.cnt);
            end
            if (e.fchk) begin
                checks++;
                if ({ForwardAE, ForwardBE, ForwardSE} !== e.fw) begin
                    errors++;
                    $display("FAIL fwd cycle %0d: got %b want %b", e.id,
                             {ForwardAE, ForwardBE, ForwardSE}, e.fw);
                end
            end
        end
    end

    initial begin
        step(0,0,0,0, 0,0,0,1,1,1, 4'b0000,2'b11,2'd0, 1,6'b000000);
        step(0,0,0,0, 0,0,0,1,1,1, 4'b0000,2'b11,2'd0, 1,6'b000000);
        // back-to-back ALU dependency on R3
        step(1,2,0,3, 1,0,0,1,0,1, 4'b0000,2'b00,2'd0, 1,6'b000000);
        step(3,3,0,4, 1,0,0,1,0,1, 4'b0000,2'b00,2'd0, 1,6'b000000);
        step(0,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b00,2'd0, 1,6'b101000);
        // R6 dependency with one intervening bubble
        step(0,0,0,6, 1,0,0,1,0,1, 4'b0000,2'b00,2'd0, 1,6'b000000);
        step(0,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b00,2'd0, 1,6'b000000);
        step(6,6,0,7, 0,0,0,1,0,1, 4'b0000,2'b00,2'd0, 1,6'b000000);
        step(0,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b00,2'd0, 1,6'b010100);
        // load-use through the shift register operand
        step(0,0,0,5, 1,1,0,1,0,1, 4'b0000,2'b00,2'd0, 1,6'b000000);
        step(0,0,5,8, 1,0,0,1,0,1, 4'b1100,2'b01,2'd0, 1,6'b000000);
        step(0,0,5,8, 1,0,0,1,0,1, 4'b0000,2'b00,2'd0, 0,6'b000000);
        step(0,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b00,2'd0, 1,6'b000001);
        // branch taken
        step(0,0,0,0, 0,0,1,1,0,1, 4'b0000,2'b11,2'd0, 0,6'b000000);
        step(0,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b10,2'd2, 0,6'b000000);
        step(0,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b00,2'd0, 0,6'b000000);
        // branch beats a pending load-use
        step(0,0,0,9, 1,1,0,1,0,1, 4'b0000,2'b00,2'd0, 0,6'b000000);
        step(9,0,0,0, 0,0,1,1,0,1, 4'b0000,2'b11,2'd0, 0,6'b000000);
        step(0,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b10,2'd2, 0,6'b000000);
        step(0,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b00,2'd0, 0,6'b000000);
        // memory wait over a load-use, then the bubble
        step(0,0,0,5, 1,1,0,1,0,1, 4'b0000,2'b00,2'd0, 0,6'b000000);
        step(5,0,0,10, 1,0,0,0,0,1, 4'b1111,2'b00,2'd0, 0,6'b000000);
        step(5,0,0,10, 1,0,0,0,0,1, 4'b1111,2'b00,2'd1, 0,6'b000000);
        step(5,0,0,10, 1,0,0,0,0,1, 4'b1111,2'b00,2'd1, 0,6'b000000);
        step(5,0,0,10, 1,0,0,1,0,1, 4'b1100,2'b01,2'd1, 0,6'b000000);
        step(5,0,0,10, 1,0,0,1,0,1, 4'b0000,2'b00,2'd0, 0,6'b000000);
        step(0,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b00,2'd0, 1,6'b010000);
        // R15 never forwarded, and a load to R15 never stalls
        step(0,0,0,15, 1,0,0,1,0,1, 4'b0000,2'b00,2'd0, 0,6'b000000);
        step(15,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b00,2'd0, 0,6'b000000);
        step(0,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b00,2'd0, 1,6'b000000);
        step(0,0,0,15, 1,1,0,1,0,1, 4'b0000,2'b00,2'd0, 0,6'b000000);
        step(15,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b00,2'd0, 0,6'b000000);
        step(0,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b00,2'd0, 0,6'b000000);
        // reset in the middle of a memory wait
        step(0,0,0,0, 0,0,0,0,0,1, 4'b1111,2'b00,2'd0, 0,6'b000000);
        step(0,0,0,0, 0,0,0,0,0,1, 4'b1111,2'b00,2'd1, 0,6'b000000);
        step(0,0,0,0, 0,0,0,0,1,1, 4'b0000,2'b11,2'd0, 1,6'b000000);
        step(0,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b00,2'd0, 0,6'b000000);
        // drive the counter up to FFFE, then saturate
        for (int i = 0; i < 65534; i++)
            step(0,0,0,0, 0,0,0,0,0,0, 4'b1111,2'b00,2'd1, 0,6'b000000);
        step(0,0,0,0, 0,0,0,0,0,1, 4'b1111,2'b00,2'd1, 0,6'b000000);
        step(0,0,0,0, 0,0,0,0,0,1, 4'b1111,2'b00,2'd1, 0,6'b000000);
        step(0,0,0,0, 0,0,0,0,0,1, 4'b1111,2'b00,2'd1, 0,6'b000000);
        step(0,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b00,2'd1, 0,6'b000000);
        step(0,0,0,0, 0,0,0,1,0,1, 4'b0000,2'b00,2'd0, 0,6'b000000);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
